// File: rtl/wb_fml_bridge.sv
// Wishbone classic slave to FastMemoryLink bridge.
// Reads are served from a single 4-word line buffer, refilled by a 4-word
// FML read burst on a miss. Writes are pushed through as a 4-word FML write
// burst carrying one enabled word, and update the line buffer on a hit.
module wb_fml_bridge #(
  parameter int adr_width = 25
) (
  input  logic                 clk,
  input  logic                 reset_n,

  input  logic [31:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  input  logic [3:0]           wb_sel_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  output logic                 wb_ack_o,

  output logic [adr_width-1:0] fml_adr,
  output logic                 fml_rd,
  output logic                 fml_wr,
  input  logic                 fml_done,
  output logic [31:0]          fml_wdat,
  output logic [3:0]           fml_wbe,
  output logic                 fml_wnext,
  input  logic                 fml_rempty,
  output logic                 fml_rnext,
  input  logic [31:0]          fml_rdat
);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_FILL,
    WR_PUSH,
    WR_REQ,
    ACK
  } state_t;

  state_t               state;
  logic [31:0]          line [4];
  logic [adr_width-5:0] tag;
  logic                 valid;
  logic [1:0]           cnt;
  logic [1:0]           word;
  logic [31:0]          wdat_q;
  logic [3:0]           sel_q;

  logic                 req;
  logic                 hit;
  logic [1:0]           aidx;
  logic                 unused_adr;

  assign req  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign hit  = valid && (wb_adr_i[adr_width-1:4] == tag);
  assign aidx = wb_adr_i[3:2];

  // Address bits outside the FML window and the byte offset are ignored.
  assign unused_adr = ^{wb_adr_i[31:adr_width], wb_adr_i[1:0]};

  // Pop the read FIFO whenever a word is available during the line fill.
  assign fml_rnext = (state == RD_FILL) & ~fml_rempty;

  // Main controller: Wishbone handshake, FML bursts and line buffer upkeep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wb_dat_o  <= '0;
      wb_ack_o  <= 1'b0;
      fml_adr   <= '0;
      fml_rd    <= 1'b0;
      fml_wr    <= 1'b0;
      fml_wdat  <= '0;
      fml_wbe   <= '0;
      fml_wnext <= 1'b0;
      tag       <= '0;
      valid     <= 1'b0;
      cnt       <= '0;
      word      <= '0;
      wdat_q    <= '0;
      sel_q     <= '0;
      for (int unsigned i = 0; i < 4; i++) line[i] <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (!wb_we_i) begin
              if (hit) begin
                wb_dat_o <= line[aidx];
                state    <= ACK;
              end else begin
                fml_adr <= {wb_adr_i[adr_width-1:4], 4'b0000};
                word    <= aidx;
                valid   <= 1'b0;
                fml_rd  <= 1'b1;
                state   <= RD_REQ;
              end
            end else begin
              if (hit) begin
                for (int unsigned b = 0; b < 4; b++)
                  if (wb_sel_i[b]) line[aidx][8*b +: 8] <= wb_dat_i[8*b +: 8];
              end
              fml_adr   <= {wb_adr_i[adr_width-1:4], 4'b0000};
              word      <= aidx;
              wdat_q    <= wb_dat_i;
              sel_q     <= wb_sel_i;
              // Word 0 goes out on the accepting edge; words 1..3 follow.
              fml_wnext <= 1'b1;
              fml_wdat  <= (aidx == 2'd0) ? wb_dat_i : '0;
              fml_wbe   <= (aidx == 2'd0) ? wb_sel_i : '0;
              cnt       <= 2'd1;
              state     <= WR_PUSH;
            end
          end
        end

        RD_REQ: begin
          if (fml_done) begin
            fml_rd <= 1'b0;
            cnt    <= '0;
            state  <= RD_FILL;
          end
        end

        RD_FILL: begin
          if (!fml_rempty) begin
            line[cnt] <= fml_rdat;
            cnt       <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              tag      <= fml_adr[adr_width-1:4];
              valid    <= 1'b1;
              // Word 3 is still in flight on this edge, so take it from the bus.
              wb_dat_o <= (word == 2'd3) ? fml_rdat : line[word];
              state    <= ACK;
            end
          end
        end

        WR_PUSH: begin
          fml_wdat <= (cnt == word) ? wdat_q : '0;
          fml_wbe  <= (cnt == word) ? sel_q  : '0;
          cnt      <= cnt + 2'd1;
          if (cnt == 2'd3) state <= WR_REQ;
        end

        WR_REQ: begin
          fml_wnext <= 1'b0;
          fml_wdat  <= '0;
          fml_wbe   <= '0;
          // The command is raised on entry, after the last data push.
          if (fml_wr && fml_done) begin
            fml_wr <= 1'b0;
            state  <= ACK;
          end else begin
            fml_wr <= 1'b1;
          end
        end

        ACK: begin
          wb_ack_o <= wb_cyc_i & wb_stb_i;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_fml_bridge.sv
// Testbench for wb_fml_bridge: directed Wishbone accesses against a small
// FML controller model, with a scoreboard monitor checking every FML
// request, write-FIFO push and Wishbone acknowledge.
module tb_wb_fml_bridge;
  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   wb_adr_i = '0;
  logic [31:0]   wb_dat_i = '0;
  logic [31:0]   wb_dat_o;
  logic [3:0]    wb_sel_i = '0;
  logic          wb_cyc_i = 1'b0;
  logic          wb_stb_i = 1'b0;
  logic          wb_we_i = 1'b0;
  logic          wb_ack_o;
  logic [AW-1:0] fml_adr;
  logic          fml_rd;
  logic          fml_wr;
  logic          fml_done = 1'b0;
  logic [31:0]   fml_wdat;
  logic [3:0]    fml_wbe;
  logic          fml_wnext;
  logic          fml_rempty = 1'b1;
  logic          fml_rnext;
  logic [31:0]   fml_rdat = '0;

  always #5 clk = ~clk;

  wb_fml_bridge #(.adr_width(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_i   (wb_sel_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_we_i    (wb_we_i),
    .wb_ack_o   (wb_ack_o),
    .fml_adr    (fml_adr),
    .fml_rd     (fml_rd),
    .fml_wr     (fml_wr),
    .fml_done   (fml_done),
    .fml_wdat   (fml_wdat),
    .fml_wbe    (fml_wbe),
    .fml_wnext  (fml_wnext),
    .fml_rempty (fml_rempty),
    .fml_rnext  (fml_rnext),
    .fml_rdat   (fml_rdat)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard queues
  logic [AW:0]  exp_req_q[$];   // {is_write, burst address}
  logic [35:0]  exp_wn_q[$];    // {wbe, wdat}
  logic [31:0]  exp_ack_q[$];
  bit           exp_ack_chk_q[$];

  // Controller model knobs
  int           delay = 3;
  bit           bubble_en = 1'b0;
  logic [31:0]  rd_words [4];
  logic [31:0]  fifo_q[$];
  int           done_count = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // FML controller model: done after 'delay' request cycles, read FIFO fill.
  bit pop_pending = 1'b0;
  int hi_cnt = 0;
  bit tog = 1'b0;
  always begin
    @(negedge clk);
    if (!reset_n) begin
      fifo_q.delete();
      hi_cnt     = 0;
      tog        = 1'b0;
      fml_done   = 1'b0;
      fml_rempty = 1'b1;
      fml_rdat   = '0;
    end else begin
      if (pop_pending && fifo_q.size() > 0) fifo_q.delete(0);
      if (fml_done) begin
        fml_done = 1'b0;
        hi_cnt   = 0;
      end else if (fml_rd || fml_wr) begin
        hi_cnt++;
        if (hi_cnt >= delay) begin
          fml_done = 1'b1;
          done_count++;
          if (fml_rd) for (int i = 0; i < 4; i++) fifo_q.push_back(rd_words[i]);
        end
      end
      tog        = ~tog;
      fml_rempty = (fifo_q.size() == 0) || (bubble_en && tog);
      fml_rdat   = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
    end
    #1 pop_pending = fml_rnext;
  end

  // Monitor: compares every DUT output event against the scoreboard.
  bit req_prev = 1'b0;
  bit prev_done = 1'b0;
  int hold = 0;
  always begin
    @(negedge clk);
    #2;
    if (reset_n) begin
      if (prev_done) check("req_drop_after_done", {fml_rd, fml_wr}, 2'b00);
      if ((fml_rd || fml_wr) && !req_prev) begin
        if (exp_req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got rd=%0b wr=%0b adr=%0h, expected none", fml_rd, fml_wr, fml_adr);
        end else begin
          check("req", {fml_wr, fml_adr}, exp_req_q.pop_front());
        end
        hold = 0;
      end
      if (fml_rd || fml_wr) hold++;
      if (!(fml_rd || fml_wr) && req_prev) check("req_hold", hold, delay);
      if (fml_wnext) begin
        if (exp_wn_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wnext: got wbe=%0h wdat=%0h, expected none", fml_wbe, fml_wdat);
        end else begin
          check("wnext", {fml_wbe, fml_wdat}, exp_wn_q.pop_front());
        end
      end
      if (wb_ack_o) begin
        if (exp_ack_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack: got dat=%0h, expected no ack", wb_dat_o);
        end else begin
          logic [31:0] d;
          bit c;
          d = exp_ack_q.pop_front();
          c = exp_ack_chk_q.pop_front();
          if (c) check("ack_data", wb_dat_o, d);
        end
      end
      req_prev  = fml_rd || fml_wr;
      prev_done = fml_done;
    end else begin
      req_prev  = 1'b0;
      prev_done = 1'b0;
    end
  end

  task automatic push_ack(input logic [31:0] d, input bit c);
    exp_ack_q.push_back(d);
    exp_ack_chk_q.push_back(c);
  endtask

  task automatic set_words(input logic [31:0] base);
    for (int i = 0; i < 4; i++) rd_words[i] = base * (i + 1);
  endtask

  task automatic wb_access(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output int lat);
    @(negedge clk);
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    wb_we_i  = we;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!wb_ack_o && lat < 300);
    if (!wb_ack_o) begin
      checks++; errors++;
      $display("FAIL ack_timeout: got no ack after %0d cycles, expected ack for adr %0h", lat, adr);
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  // Start a read and return once the FML read command has been accepted.
  task automatic start_read_to_fill(input logic [31:0] adr, input string name);
    int n;
    @(negedge clk);
    wb_adr_i = adr;
    wb_we_i  = 1'b0;
    wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    n = 0;
    while (!fml_rd && n < 50) begin @(negedge clk); n++; end
    check({name, "_rd_rise"}, fml_rd, 1'b1);
    n = 0;
    while (fml_rd && n < 50) begin @(negedge clk); n++; end
    check({name, "_rd_fall"}, fml_rd, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int lat;
    int dc0;
    #500000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int dc0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_ctl", {wb_ack_o, fml_rd, fml_wr, fml_wnext, fml_rnext}, 5'b0);
    check("rst_adr", fml_adr, 0);
    check("rst_dat", wb_dat_o, 0);
    check("rst_wr", {fml_wbe, fml_wdat}, 0);
    @(negedge clk);
    #3 reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Read miss, done 3 cycles after fml_rd, no bubbles
    delay = 3;
    rd_words[0] = 32'h11111111; rd_words[1] = 32'h22222222;
    rd_words[2] = 32'h33333333; rd_words[3] = 32'h44444444;
    exp_req_q.push_back({1'b0, 25'h100});
    push_ack(32'h22222222, 1'b1);
    dc0 = done_count;
    wb_access(1'b0, 32'h0000_0104, 32'h0, 4'hF, lat);
    check("miss_lat", lat, 9);
    check("miss_done_cnt", done_count - dc0, 1);

    // Read hit in the same line
    push_ack(32'h44444444, 1'b1);
    wb_access(1'b0, 32'h0000_010C, 32'h0, 4'hF, lat);
    check("hit_lat", lat, 2);

    // Write with hit, partial byte enables
    exp_wn_q.push_back({4'b0000, 32'h0});
    exp_wn_q.push_back({4'b0000, 32'h0});
    exp_wn_q.push_back({4'b0110, 32'hAABBCCDD});
    exp_wn_q.push_back({4'b0000, 32'h0});
    exp_req_q.push_back({1'b1, 25'h100});
    push_ack(32'h0, 1'b0);
    wb_access(1'b1, 32'h0000_0108, 32'hAABBCCDD, 4'b0110, lat);

    // Read back the merged word from the line buffer
    push_ack(32'h33BBCC33, 1'b1);
    wb_access(1'b0, 32'h0000_0108, 32'h0, 4'hF, lat);
    check("hit_lat_after_wr", lat, 2);

    // Done held off for 20 cycles: read miss then sel=0000 write
    delay = 20;
    set_words(32'h0A0A0A0A);
    exp_req_q.push_back({1'b0, 25'h2000});
    push_ack(32'h0A0A0A0A, 1'b1);
    wb_access(1'b0, 32'h0000_2000, 32'h0, 4'hF, lat);
    exp_wn_q.push_back({4'b0000, 32'h0});
    exp_wn_q.push_back({4'b0000, 32'h12345678});
    exp_wn_q.push_back({4'b0000, 32'h0});
    exp_wn_q.push_back({4'b0000, 32'h0});
    exp_req_q.push_back({1'b1, 25'h2000});
    push_ack(32'h0, 1'b0);
    wb_access(1'b1, 32'h0000_2004, 32'h12345678, 4'b0000, lat);
    push_ack(32'h14141414, 1'b1);
    wb_access(1'b0, 32'h0000_2004, 32'h0, 4'hF, lat);

    // Empty bubbles and master abort during the fill
    delay = 3;
    bubble_en = 1'b1;
    set_words(32'h0B0B0B0B);
    exp_req_q.push_back({1'b0, 25'h3000});
    start_read_to_fill(32'h0000_3008, "abort");
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_fifo_drained", fifo_q.size(), 0);
    bubble_en = 1'b0;
    push_ack(32'h2C2C2C2C, 1'b1);
    wb_access(1'b0, 32'h0000_300C, 32'h0, 4'hF, lat);
    check("abort_next_hit_lat", lat, 2);

    // Asynchronous reset in the middle of a fill
    bubble_en = 1'b1;
    set_words(32'h0C0C0C0C);
    exp_req_q.push_back({1'b0, 25'h4000});
    start_read_to_fill(32'h0000_4000, "arst");
    #3 reset_n = 1'b0;
    #1;
    check("arst_ctl", {wb_ack_o, fml_rd, fml_wr, fml_wnext, fml_rnext}, 5'b0);
    check("arst_adr", fml_adr, 0);
    check("arst_dat", wb_dat_o, 0);
    check("arst_wr", {fml_wbe, fml_wdat}, 0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    bubble_en = 1'b0;
    repeat (2) @(negedge clk);
    #3 reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Line buffer must be invalid after reset: a former hit now misses
    set_words(32'h0B0B0B0B);
    exp_req_q.push_back({1'b0, 25'h3000});
    push_ack(32'h2C2C2C2C, 1'b1);
    wb_access(1'b0, 32'h0000_300C, 32'h0, 4'hF, lat);
    check("post_rst_miss_lat", lat, 9);

    repeat (5) @(negedge clk);
    check("sb_empty", exp_req_q.size() + exp_wn_q.size() + exp_ack_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
